im_loader: RTL

Program loader for the single-cycle MIPS core: the writer side of the instruction-memory interface the core reads each fetch. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them to the IM write port at consecutive word addresses. It verifies a trailing checksum and holds the core in reset until a load completes cleanly. It sits beside the CPU top level, between an external byte source (UART receiver or testbench) and the IM.

---
 rtl/im_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-stream program loader writing big-endian words into instruction memory
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state;
    state_t      next_state;

    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [31:0] addr_cnt;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [23:0] shift_reg;

    logic        accept;
    logic        load_start;
    logic [15:0] len_word;
    logic [7:0]  csum_next;
    logic        last_byte;
    logic        last_word;

    assign accept     = in_valid && in_ready;
    assign load_start = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign len_word   = {len_hi, in_data};
    assign csum_next  = csum + in_data;
    assign last_byte  = (byte_idx == 2'd3);
    // word_cnt already counts completed words, so the word in flight is the last one
    // when one more completion reaches LEN.
    assign last_word  = ((word_cnt + 16'd1) == len);

    // State register; reset discards any load in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (accept) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (len_word == 16'd0) begin
                        next_state = S_CSUM;
                    end else if (len_word > MAX_LEN) begin
                        next_state = S_ERROR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (accept && last_byte && last_word) next_state = S_CSUM;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (accept) next_state = (csum_next == 8'h00) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) next_state = S_LEN_HI;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) next_state = S_LEN_HI;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Checksum, length capture, word assembly and the registered IM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum      <= 8'h00;
            byte_idx  <= 2'd0;
            addr_cnt  <= 32'h0000_0000;
            len_hi    <= 8'h00;
            len       <= 16'h0000;
            shift_reg <= 24'h000000;
            word_cnt  <= 16'h0000;
            im_we     <= 1'b0;
            im_addr   <= 32'h0000_0000;
            im_wdata  <= 32'h0000_0000;
        end else begin
            im_we <= 1'b0;
            if (load_start) begin
                csum     <= 8'h00;
                byte_idx <= 2'd0;
                word_cnt <= 16'h0000;
                addr_cnt <= BASE_ADDR;
            end else if (accept) begin
                csum <= csum_next;
                case (state)
                    S_LEN_HI: len_hi <= in_data;
                    S_LEN_LO: len    <= len_word;
                    S_DATA: begin
                        byte_idx  <= byte_idx + 2'd1;
                        shift_reg <= {shift_reg[15:0], in_data};
                        if (last_byte) begin
                            im_we    <= 1'b1;
                            im_addr  <= addr_cnt;
                            im_wdata <= {shift_reg, in_data};
                            addr_cnt <= addr_cnt + 32'd4;
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
